// File: rtl/result_select_sequencer_pkg.sv
// Shared constants for the result select sequencer: default sizing and
// the legacy-compatible state encoding used by the control FSM.
package resultSeqPkg;

   localparam int RSS_NUM_UNITS = 4;
   localparam int RSS_REG_W     = 5;
   localparam int RSS_TIMEOUT   = 64;

   typedef logic [1:0] rss_state_t;

   localparam rss_state_t ST_IDLE = 2'd0;
   localparam rss_state_t ST_WAIT = 2'd1;
   localparam rss_state_t ST_LOAD = 2'd2;

endpackage

// File: rtl/result_select_sequencer_timeout.sv
// Wait-cycle counter for the result select sequencer. Counts enabled WAIT
// cycles and flags the cycle in which the last permitted wait is reached.
module result_timeout_counter
   import resultSeqPkg::*;
#(
   parameter int TIMEOUT = RSS_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Clear has priority; otherwise count up on request, else hold.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + ONE_C;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = (count_q == LAST_C);

endmodule

// File: rtl/result_select_sequencer.sv
// Result select sequencer: tracks one outstanding operation, waits for its
// result source to report done (or times out), and emits a one-cycle
// registered load pulse with the selected source and writeback address.
module result_select_sequencer
   import resultSeqPkg::*;
#(
   parameter int NUM_UNITS = RSS_NUM_UNITS,
   parameter int UNIT_W    = $clog2(NUM_UNITS),
   parameter int REG_W     = RSS_REG_W,
   parameter int TIMEOUT   = RSS_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 flush,
   input  logic                 issue_valid,
   input  logic [UNIT_W-1:0]    issue_unit,
   input  logic [REG_W-1:0]     issue_dest,
   input  logic [NUM_UNITS-1:0] unit_done,
   output logic                 result_load,
   output logic [UNIT_W-1:0]    result_sel,
   output logic [REG_W-1:0]     result_dest,
   output logic                 busy,
   output logic                 timeout_err
);

   // One extra bit so the unit count itself is representable.
   localparam logic [UNIT_W:0] UNIT_LIMIT_C = (UNIT_W + 1)'(NUM_UNITS);

   rss_state_t        state_q, state_d;
   logic [UNIT_W-1:0] pend_unit_q, pend_unit_d;
   logic [REG_W-1:0]  pend_dest_q, pend_dest_d;
   logic              load_q, load_d;
   logic [UNIT_W-1:0] sel_q, sel_d;
   logic [REG_W-1:0]  dest_q, dest_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic accept_s;
   logic done_sel_s;
   logic expire_s;
   logic stay_wait_s;
   logic cnt_clear_s;
   logic cnt_inc_s;

   // Only the pending unit's done flag matters; others are ignored.
   assign done_sel_s = unit_done[pend_unit_q];

   // An issue is taken only outside WAIT, unflushed, enabled, and in range.
   assign accept_s = enable & ~flush & (state_q != ST_WAIT) & issue_valid
                     & ({1'b0, issue_unit} < UNIT_LIMIT_C);

   // The counter runs only while WAIT persists; any other transition clears it.
   assign stay_wait_s = (state_q == ST_WAIT) & (state_d == ST_WAIT);
   assign cnt_inc_s   = enable & stay_wait_s;
   assign cnt_clear_s = enable & ~stay_wait_s;

   result_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear_s),
      .inc    (cnt_inc_s),
      .expire (expire_s)
   );

   // Next state and next registered outputs; a stall holds everything.
   always_comb begin
      state_d     = state_q;
      pend_unit_d = pend_unit_q;
      pend_dest_d = pend_dest_q;
      load_d      = load_q;
      sel_d       = sel_q;
      dest_d      = dest_q;
      busy_d      = busy_q;
      err_d       = err_q;
      if (enable) begin
         if (flush) begin
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE, ST_LOAD: begin
                  if (accept_s) begin
                     pend_unit_d = issue_unit;
                     pend_dest_d = issue_dest;
                     if (issue_unit == '0) begin
                        state_d = ST_LOAD;
                     end else begin
                        state_d = ST_WAIT;
                     end
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
               ST_WAIT: begin
                  // Done beats timeout when both land in the same cycle.
                  if (done_sel_s) begin
                     state_d = ST_LOAD;
                  end else if (expire_s) begin
                     state_d = ST_IDLE;
                     err_d   = 1'b1;
                  end else begin
                     state_d = ST_WAIT;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
         load_d = (state_d == ST_LOAD);
         busy_d = (state_d == ST_WAIT);
         if (load_d) begin
            sel_d  = pend_unit_d;
            dest_d = pend_dest_d;
         end else begin
            sel_d  = sel_q;
            dest_d = dest_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State, pending fields and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pend_unit_q <= '0;
         pend_dest_q <= '0;
         load_q      <= 1'b0;
         sel_q       <= '0;
         dest_q      <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_unit_q <= pend_unit_d;
         pend_dest_q <= pend_dest_d;
         load_q      <= load_d;
         sel_q       <= sel_d;
         dest_q      <= dest_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign result_load = load_q;
   assign result_sel  = sel_q;
   assign result_dest = dest_q;
   assign busy        = busy_q;
   assign timeout_err = err_q;

endmodule
